// File: rtl/tick_sched_pkg.sv
// tick_sched_pkg: shared state enums, mode encodings and index-width helper for tick_sched
package tick_sched_pkg;
  typedef enum logic {READY, APPLY} cfg_state_t;
  typedef enum logic {IDLE, RUN} ch_state_t;
  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: registered base_tick pulse every BASE_DIV clks; TICK_SCHED_PAUSE_EN adds a pause input
module tick_prescaler #(
  parameter int BASE_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
`ifdef TICK_SCHED_PAUSE_EN
  input  logic pause,
`endif
  output logic base_tick
);
  localparam int W = $clog2(BASE_DIV);
  logic [W-1:0] cnt;
  logic         run;
`ifdef TICK_SCHED_PAUSE_EN
  assign run = !pause;
`else
  assign run = 1'b1;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      base_tick <= 1'b0;
    end else if (!run) begin
      base_tick <= 1'b0;
    end else begin
      base_tick <= cnt == W'(BASE_DIV - 1);
      cnt       <= (cnt == W'(BASE_DIV - 1)) ? '0 : cnt + W'(1);
    end
  end
endmodule

// File: rtl/tick_sched.sv
// tick_sched: shared prescaler plus NUM_CH programmable one-shot/periodic tick channels.
// Optional TICK_SCHED_PAUSE_EN adds a pause input that freezes the prescaler.
module tick_sched
  import tick_sched_pkg::*;
#(
  parameter int BASE_DIV = 50000,
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
`ifdef TICK_SCHED_PAUSE_EN
  input  logic                        pause,
`endif
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [ch_idx_w(NUM_CH)-1:0] cfg_ch,
  input  logic                        cfg_start,
  input  logic                        cfg_mode,
  input  logic [CNT_W-1:0]            cfg_period,
  output logic                        cfg_err,
  output logic                        base_tick,
  output logic [NUM_CH-1:0]           ch_tick,
  output logic [NUM_CH-1:0]           ch_busy
);
  localparam int CH_W = ch_idx_w(NUM_CH);
  cfg_state_t       state, state_nx;
  logic [CH_W-1:0]  a_ch;
  logic             a_start, a_mode;
  logic [CNT_W-1:0] a_per;

  tick_prescaler #(.BASE_DIV(BASE_DIV)) u_presc (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef TICK_SCHED_PAUSE_EN
    .pause    (pause),
`endif
    .base_tick(base_tick)
  );

  always_comb begin
    cfg_ready = state == READY;
    state_nx  = (state == APPLY) ? READY : (cfg_valid ? APPLY : READY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= READY;
      a_ch    <= '0;
      a_start <= 1'b0;
      a_mode  <= MODE_ONESHOT;
      a_per   <= '0;
      cfg_err <= 1'b0;
    end else begin
      state   <= state_nx;
      cfg_err <= state == APPLY && a_start && a_per == '0;
      if (cfg_valid && cfg_ready) begin
        a_ch    <= cfg_ch;
        a_start <= cfg_start;
        a_mode  <= cfg_mode;
        a_per   <= cfg_period;
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ch_state_t        st;
    logic [CNT_W-1:0] cnt, per;
    logic             mode, tick, hit;
    assign hit        = state == APPLY && a_ch == CH_W'(i);
    assign ch_tick[i] = tick;
    assign ch_busy[i] = st == RUN;
    // A config write to this channel overrides any base tick landing in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st   <= IDLE;
        cnt  <= '0;
        per  <= '0;
        mode <= MODE_ONESHOT;
        tick <= 1'b0;
      end else begin
        tick <= 1'b0;
        if (hit) begin
          if (a_start && a_per != '0) begin
            st   <= RUN;
            cnt  <= a_per - CNT_W'(1);
            per  <= a_per;
            mode <= a_mode;
          end else if (!a_start) begin
            st  <= IDLE;
            cnt <= '0;
          end
        end else if (st == RUN && base_tick) begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            tick <= 1'b1;
            if (mode == MODE_PERIODIC) cnt <= per - CNT_W'(1);
            else st <= IDLE;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_tick_sched.sv
// tb_tick_sched: directed + random stimulus for tick_sched checked against a base-tick-countdown model
module tb_tick_sched;
  localparam int BD = 4;
  localparam int NC = 4;
  localparam int CW = 8;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          cfg_valid = 1'b0, cfg_start = 1'b0, cfg_mode = 1'b0;
  logic [1:0]    cfg_ch = '0;
  logic [CW-1:0] cfg_period = '0;
  logic          cfg_ready, cfg_err, base_tick;
  logic [NC-1:0] ch_tick, ch_busy;
`ifdef TICK_SCHED_PAUSE_EN
  logic          pause = 1'b0;
`endif

  tick_sched #(.BASE_DIV(BD), .NUM_CH(NC), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef TICK_SCHED_PAUSE_EN
    .pause     (pause),
`endif
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_start (cfg_start),
    .cfg_mode  (cfg_mode),
    .cfg_period(cfg_period),
    .cfg_err   (cfg_err),
    .base_tick (base_tick),
    .ch_tick   (ch_tick),
    .ch_busy   (ch_busy)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  // Model: edges since reset release, pending request, and base ticks remaining per channel.
  int ecount;
  bit m_bt, pend, m_err, p_start, p_mode;
  int p_ch, p_per;
  bit m_tick[NC], m_busy[NC], m_mode[NC];
  int rem[NC], m_per[NC];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    ecount = 0; m_bt = 0; pend = 0; m_err = 0;
    for (int i = 0; i < NC; i++) begin
      m_tick[i] = 0; m_busy[i] = 0; rem[i] = 0;
    end
  endtask

  task automatic model_edge();
    bit ob, op;
    ob = m_bt;
    op = pend;
    ecount++;
    for (int i = 0; i < NC; i++) begin
      m_tick[i] = 0;
      if (op && p_ch == i) begin
        if (p_start && p_per != 0) begin
          m_busy[i] = 1; rem[i] = p_per; m_per[i] = p_per; m_mode[i] = p_mode;
        end else if (!p_start) m_busy[i] = 0;
      end else if (m_busy[i] && ob) begin
        rem[i]--;
        if (rem[i] == 0) begin
          m_tick[i] = 1;
          if (m_mode[i]) rem[i] = m_per[i];
          else m_busy[i] = 0;
        end
      end
    end
    m_err = op && p_start && p_per == 0;
    if (op) pend = 0;
    else if (cfg_valid) begin
      pend = 1; p_ch = cfg_ch; p_start = cfg_start; p_mode = cfg_mode; p_per = cfg_period;
    end
    m_bt = (ecount % BD) == 0;
  endtask

  task automatic compare();
    logic [NC-1:0] et, eb;
    for (int i = 0; i < NC; i++) begin
      et[i] = m_tick[i];
      eb[i] = m_busy[i];
    end
    check("cfg_ready", cfg_ready, !pend);
    check("cfg_err", cfg_err, m_err);
    check("base_tick", base_tick, m_bt);
    check("ch_tick", ch_tick, et);
    check("ch_busy", ch_busy, eb);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (!rst_n) model_reset();
    else model_edge();
    compare();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic send(input int ch, input bit st, input bit md, input int per);
    cfg_valid = 1; cfg_ch = 2'(ch); cfg_start = st; cfg_mode = md; cfg_period = CW'(per);
    step();
    cfg_valid = 0;
  endtask

  initial begin
    model_reset();
    #1;
    check("rst_ready", cfg_ready, 1);
    check("rst_busy", ch_busy, 0);
    run(3);
    rst_n = 1;
    run(12);
    // periodic ch0, P=3
    send(0, 1, 1, 3);
    run(64);
    // one-shot ch1 with a back-to-back illegal request to ch2
    cfg_valid = 1; cfg_ch = 2'd1; cfg_start = 1; cfg_mode = 0; cfg_period = 8'd2;
    step();
    check("rdy_in_apply", cfg_ready, 0);
    cfg_ch = 2'd2; cfg_period = 8'd0;
    step();
    step();
    cfg_valid = 0;
    run(2);
    check("err_busy2", ch_busy[2], 0);
    run(20);
    // stop ch0
    send(0, 0, 0, 0);
    run(40);
    check("stop_busy0", ch_busy[0], 0);
    // collision: ch3 at P=1 sits at count 0 on every base tick
    send(3, 1, 1, 1);
    run(9);
    for (int k = 0; k < BD && ((ecount + 1) % BD) != 0; k++) step();
    send(3, 1, 1, 5);
    step();
    check("collide_tick3", ch_tick[3], 0);
    check("collide_busy3", ch_busy[3], 1);
    run(26);
    // random traffic
    for (int k = 0; k < 300; k++) begin
      cfg_valid  = $urandom_range(2) == 0;
      cfg_ch     = 2'($urandom_range(3));
      cfg_start  = $urandom_range(7) != 0;
      cfg_mode   = 1'($urandom_range(1));
      cfg_period = CW'($urandom_range(6));
      step();
    end
    cfg_valid = 0;
    run(2);
    // reset mid-run
    send(0, 1, 1, 2);
    run(1);
    send(1, 1, 1, 3);
    run(21);
    #1;
    rst_n = 0;
    #1;
    check("arst_busy", ch_busy, 0);
    check("arst_tick", ch_tick, 0);
    check("arst_bt", base_tick, 0);
    check("arst_ready", cfg_ready, 1);
    step();
    rst_n = 1;
    run(40);
    check("post_rst_busy", ch_busy, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tick_sched.md
Name: tick_sched

Overview:
Multi-channel timer scheduler. One shared base-tick prescaler drives NUM_CH independently programmable channel down-counters. Each channel emits a one-cycle tick after a programmed number of base ticks, either once or periodically. It sits between the system clock and blocks needing timed events, such as display refresh, digit-advance counters and LED blink timers, so each of those no longer needs its own wide divider.

Parameters:
BASE_DIV, 50000, clk cycles per base tick (1 ms at 50 MHz); must be >= 2.
NUM_CH, 4, number of channels; 2..16.
CNT_W, 16, channel period width in base ticks.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
cfg_valid  in  1  config request
cfg_ready  out  1  config accept; a transfer occurs when cfg_valid && cfg_ready
cfg_ch  in  $clog2(NUM_CH)  target channel
cfg_start  in  1  1 = start/restart, 0 = stop
cfg_mode  in  1  0 = one-shot, 1 = periodic
cfg_period  in  CNT_W  period in base ticks; 0 is illegal
cfg_err  out  1  one-cycle pulse: rejected request
base_tick  out  1  one-cycle pulse every BASE_DIV clks
ch_tick  out  NUM_CH  per-channel one-cycle event pulse
ch_busy  out  NUM_CH  channel running

Behaviour:
- Reset: all outputs 0 except cfg_ready = 1. Prescaler = 0. All channels IDLE with count 0.
- Asserting rst_n low mid-operation aborts every channel immediately. There is no tick on the release edge.
- Prescaler: counts 0..BASE_DIV-1 and wraps.
  - base_tick (registered) is high in the cycle after the count equals BASE_DIV-1.
  - The first base_tick is BASE_DIV cycles after reset release; thereafter it repeats every BASE_DIV clks.
- Config FSM states: READY → APPLY → READY.
  - READY: cfg_ready = 1. On transfer, capture the fields and go to APPLY.
  - APPLY: cfg_ready = 0. Update the target channel, then return to READY.
  - Result: at most one transfer every 2 clks.
- APPLY, start with period P ≠ 0: count ← P-1, mode latched, channel RUN, ch_busy = 1 from the next cycle.
  - A start to a running channel restarts it.
- APPLY, stop: channel IDLE, count ← 0, ch_busy = 0. No tick is generated.
- APPLY, start with P = 0: cfg_err pulses for 1 cycle (the cycle after APPLY). The channel is unchanged.
- Channel in RUN, on each cycle where base_tick = 1:
  - count ≠ 0: count ← count-1.
  - count = 0: ch_tick[i] pulses on the next cycle.
    - Periodic: count ← P-1.
    - One-shot: channel goes IDLE; ch_busy[i] drops in the same cycle ch_tick[i] is high.
- Timing: ch_tick therefore occurs every P base ticks. The first tick follows the P-th base_tick strictly after APPLY.
- Collision: APPLY to channel i in the same cycle as base_tick means config wins.
  - Channel i does not decrement and emits no ch_tick.
  - Other channels are unaffected.
- Simultaneous: several channels may tick in the same cycle; there is no arbitration between them.
- Arithmetic: unsigned, wrap-free. count never underflows because the reload happens at 0.

Optional Feature:
TICK_SCHED_PAUSE_EN
- Defined: adds input port pause (1 bit).
  - While pause = 1, the prescaler holds its value and base_tick stays 0, so all channels freeze.
  - Config transfers are still accepted and applied.
  - Releasing pause resumes counting from the held value.
- Undefined: no pause port; the prescaler is free-running.

Decomposition:
- Package tick_sched_pkg holds:
  - cfg FSM state enum (READY, APPLY).
  - channel state enum (IDLE, RUN).
  - mode constants MODE_ONESHOT = 0, MODE_PERIODIC = 1.
  - function for the channel index width.
- Sub-module tick_prescaler (BASE_DIV; clk, rst_n, optional pause, base_tick) produces the base tick.
- Channel counters are generated with a generate loop in the top level.

Test Plan:
All scenarios use BASE_DIV = 4, NUM_CH = 4, CNT_W = 8.
- Reset: hold rst_n low 3 clks → all outputs 0, cfg_ready = 1. First base_tick 4 clks after release, then every 4 clks.
- Periodic: ch0 start, mode 1, P = 3 → ch_busy[0] = 1. ch_tick[0] every 12 clks, the first 1 cycle after the 3rd post-APPLY base_tick. Five ticks are checked.
- One-shot plus handshake: ch1 start, mode 0, P = 2 → exactly one ch_tick[1], and ch_busy[1] falls with it. A back-to-back cfg_valid sees cfg_ready = 0 in the APPLY cycle.
- Illegal and stop: ch2 start with P = 0 → cfg_err pulses once and ch_busy[2] stays 0. Then stop ch0 while it is running → no further ch_tick[0].
- Collision: time a restart of ch3 (P = 5) so APPLY coincides with base_tick while count = 0 → no ch_tick[3] in the next cycle. The next tick arrives 5 base ticks later.
- Reset mid-run: ch0 and ch1 periodic, assert rst_n low for 1 clk → all busy/tick 0 immediately. After release, no ticks occur until reconfigured.
